// File: rtl/cc_level_sequencer_player_2.sv
// Level sequencer: walks progress indices through three levels, fetching one
// obstacle row from the level ROM per scroll step and flagging level/game end.
module cc_level_sequencer_player_2 #(
  parameter int unsigned LEVEL_DATAHANDLER_DATAWIDTH = 8,
  parameter int unsigned CURRENTLEVEL_DATAWIDTH      = 3,
  parameter int unsigned LEVELPROGRESS_DATAWIDTH     = 5,
  parameter int unsigned LVL1_LENGTH                 = 10,
  parameter int unsigned LVL2_LENGTH                 = 15,
  parameter int unsigned LVL3_LENGTH                 = 20
) (
  input  logic                                   CC_LEVEL_SEQUENCER_PLAYER_2_CLOCK_50,
  input  logic                                   CC_LEVEL_SEQUENCER_PLAYER_2_RESET_InHigh,
  input  logic                                   CC_LEVEL_SEQUENCER_PLAYER_2_Start_In,
  input  logic                                   CC_LEVEL_SEQUENCER_PLAYER_2_Step_In,
  input  logic                                   CC_LEVEL_SEQUENCER_PLAYER_2_Pause_In,
  input  logic [LEVEL_DATAHANDLER_DATAWIDTH-1:0] CC_LEVEL_SEQUENCER_PLAYER_2_LevelData_InBus,
  output logic [CURRENTLEVEL_DATAWIDTH-1:0]      CC_LEVEL_SEQUENCER_PLAYER_2_CurrentLvl_OutBus,
  output logic [LEVELPROGRESS_DATAWIDTH-1:0]     CC_LEVEL_SEQUENCER_PLAYER_2_LvlProgress_OutBus,
  output logic [LEVEL_DATAHANDLER_DATAWIDTH-1:0] CC_LEVEL_SEQUENCER_PLAYER_2_ObstacleRow_OutBus,
  output logic                                   CC_LEVEL_SEQUENCER_PLAYER_2_RowValid_Out,
  output logic                                   CC_LEVEL_SEQUENCER_PLAYER_2_LevelDone_Out,
  output logic                                   CC_LEVEL_SEQUENCER_PLAYER_2_GameDone_Out,
  output logic                                   CC_LEVEL_SEQUENCER_PLAYER_2_DataErr_Out
);

  localparam int unsigned LW = CURRENTLEVEL_DATAWIDTH;
  localparam int unsigned PW = LEVELPROGRESS_DATAWIDTH;
  localparam int unsigned DW = LEVEL_DATAHANDLER_DATAWIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    LVL_END = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        stateReg, stateNext;
  logic [LW-1:0] lvlNext;
  logic [PW-1:0] progNext;
  logic [DW-1:0] rowNext;
  logic          rowValidNext, levelDoneNext, gameDoneNext, dataErrNext;
  logic [PW-1:0] levelLength;

  logic stepAccepted;
  assign stepAccepted = CC_LEVEL_SEQUENCER_PLAYER_2_Step_In & ~CC_LEVEL_SEQUENCER_PLAYER_2_Pause_In;

  // Last valid progress index of the level currently being played.
  always_comb begin
    levelLength = PW'(LVL1_LENGTH);
    case (CC_LEVEL_SEQUENCER_PLAYER_2_CurrentLvl_OutBus)
      LW'(4):  levelLength = PW'(LVL2_LENGTH);
      LW'(6):  levelLength = PW'(LVL3_LENGTH);
      default: levelLength = PW'(LVL1_LENGTH);
    endcase
  end

  always_ff @(posedge CC_LEVEL_SEQUENCER_PLAYER_2_CLOCK_50) begin
    if (CC_LEVEL_SEQUENCER_PLAYER_2_RESET_InHigh) begin
      stateReg                                       <= IDLE;
      CC_LEVEL_SEQUENCER_PLAYER_2_CurrentLvl_OutBus  <= '0;
      CC_LEVEL_SEQUENCER_PLAYER_2_LvlProgress_OutBus <= '0;
      CC_LEVEL_SEQUENCER_PLAYER_2_ObstacleRow_OutBus <= '0;
      CC_LEVEL_SEQUENCER_PLAYER_2_RowValid_Out       <= 1'b0;
      CC_LEVEL_SEQUENCER_PLAYER_2_LevelDone_Out      <= 1'b0;
      CC_LEVEL_SEQUENCER_PLAYER_2_GameDone_Out       <= 1'b0;
      CC_LEVEL_SEQUENCER_PLAYER_2_DataErr_Out        <= 1'b0;
    end else begin
      stateReg                                       <= stateNext;
      CC_LEVEL_SEQUENCER_PLAYER_2_CurrentLvl_OutBus  <= lvlNext;
      CC_LEVEL_SEQUENCER_PLAYER_2_LvlProgress_OutBus <= progNext;
      CC_LEVEL_SEQUENCER_PLAYER_2_ObstacleRow_OutBus <= rowNext;
      CC_LEVEL_SEQUENCER_PLAYER_2_RowValid_Out       <= rowValidNext;
      CC_LEVEL_SEQUENCER_PLAYER_2_LevelDone_Out      <= levelDoneNext;
      CC_LEVEL_SEQUENCER_PLAYER_2_GameDone_Out       <= gameDoneNext;
      CC_LEVEL_SEQUENCER_PLAYER_2_DataErr_Out        <= dataErrNext;
    end
  end

  // Start restarts from any state; pulses default low, everything else holds.
  always_comb begin
    stateNext     = stateReg;
    lvlNext       = CC_LEVEL_SEQUENCER_PLAYER_2_CurrentLvl_OutBus;
    progNext      = CC_LEVEL_SEQUENCER_PLAYER_2_LvlProgress_OutBus;
    rowNext       = CC_LEVEL_SEQUENCER_PLAYER_2_ObstacleRow_OutBus;
    rowValidNext  = 1'b0;
    levelDoneNext = 1'b0;
    gameDoneNext  = CC_LEVEL_SEQUENCER_PLAYER_2_GameDone_Out;
    dataErrNext   = CC_LEVEL_SEQUENCER_PLAYER_2_DataErr_Out;

    if (CC_LEVEL_SEQUENCER_PLAYER_2_Start_In) begin
      stateNext    = FETCH;
      lvlNext      = LW'(2);
      progNext     = PW'(1);
      gameDoneNext = 1'b0;
      dataErrNext  = 1'b0;
    end else begin
      case (stateReg)
        FETCH: begin
          rowNext      = CC_LEVEL_SEQUENCER_PLAYER_2_LevelData_InBus;
          rowValidNext = 1'b1;
          if (CC_LEVEL_SEQUENCER_PLAYER_2_LevelData_InBus == '0) dataErrNext = 1'b1;
          stateNext    = WAIT;
        end
        WAIT: begin
          if (stepAccepted) begin
            if (CC_LEVEL_SEQUENCER_PLAYER_2_LvlProgress_OutBus < levelLength) begin
              progNext  = CC_LEVEL_SEQUENCER_PLAYER_2_LvlProgress_OutBus + PW'(1);
              stateNext = FETCH;
            end else begin
              levelDoneNext = 1'b1;
              stateNext     = LVL_END;
            end
          end
        end
        LVL_END: begin
          if (CC_LEVEL_SEQUENCER_PLAYER_2_CurrentLvl_OutBus < LW'(6)) begin
            lvlNext   = CC_LEVEL_SEQUENCER_PLAYER_2_CurrentLvl_OutBus + LW'(2);
            progNext  = PW'(1);
            stateNext = FETCH;
          end else begin
            gameDoneNext = 1'b1;
            lvlNext      = '0;
            progNext     = '0;
            stateNext    = DONE;
          end
        end
        default: stateNext = stateReg;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_level_sequencer_player_2.sv
// Directed bench for the level sequencer with a small behavioural level ROM.
module tb_cc_level_sequencer_player_2;

  logic       clk = 1'b0;
  logic       rst, start, step, pause, forceZero;
  logic [7:0] levelData;
  logic [2:0] lvl;
  logic [4:0] prog;
  logic [7:0] row;
  logic       rowValid, levelDone, gameDone, dataErr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cc_level_sequencer_player_2 dut (
    .CC_LEVEL_SEQUENCER_PLAYER_2_CLOCK_50          (clk),
    .CC_LEVEL_SEQUENCER_PLAYER_2_RESET_InHigh      (rst),
    .CC_LEVEL_SEQUENCER_PLAYER_2_Start_In          (start),
    .CC_LEVEL_SEQUENCER_PLAYER_2_Step_In           (step),
    .CC_LEVEL_SEQUENCER_PLAYER_2_Pause_In          (pause),
    .CC_LEVEL_SEQUENCER_PLAYER_2_LevelData_InBus   (levelData),
    .CC_LEVEL_SEQUENCER_PLAYER_2_CurrentLvl_OutBus (lvl),
    .CC_LEVEL_SEQUENCER_PLAYER_2_LvlProgress_OutBus(prog),
    .CC_LEVEL_SEQUENCER_PLAYER_2_ObstacleRow_OutBus(row),
    .CC_LEVEL_SEQUENCER_PLAYER_2_RowValid_Out      (rowValid),
    .CC_LEVEL_SEQUENCER_PLAYER_2_LevelDone_Out     (levelDone),
    .CC_LEVEL_SEQUENCER_PLAYER_2_GameDone_Out      (gameDone),
    .CC_LEVEL_SEQUENCER_PLAYER_2_DataErr_Out       (dataErr)
  );

  // Level ROM: first row 0x02, last row 0x04 (0x02 for the final level), else prog*4.
  function automatic logic [7:0] rom(input logic [2:0] l, input logic [4:0] p);
    if (l == 3'd0 || p == 5'd0) return 8'h00;
    if (p == 5'd1) return 8'h02;
    if ((l == 3'd2 && p == 5'd10) || (l == 3'd4 && p == 5'd15)) return 8'h04;
    if (l == 3'd6 && p == 5'd20) return 8'h02;
    return {1'b0, p, 2'b00};
  endfunction

  assign levelData = forceZero ? 8'h00 : rom(lvl, prog);

  typedef struct {
    logic       start, step, pause;
    logic [2:0] lvl;
    logic [4:0] prog;
    logic [7:0] row;
    logic       rv, ld, gd, err;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] eLvl, input logic [4:0] eProg,
                          input logic [7:0] eRow, input logic eRv, input logic eLd,
                          input logic eGd, input logic eErr);
    checkVal({tag, ".lvl"},       32'(lvl),       32'(eLvl));
    checkVal({tag, ".prog"},      32'(prog),      32'(eProg));
    checkVal({tag, ".row"},       32'(row),       32'(eRow));
    checkVal({tag, ".rowValid"},  32'(rowValid),  32'(eRv));
    checkVal({tag, ".levelDone"}, 32'(levelDone), 32'(eLd));
    checkVal({tag, ".gameDone"},  32'(gameDone),  32'(eGd));
    checkVal({tag, ".dataErr"},   32'(dataErr),   32'(eErr));
  endtask

  // One accepted step followed by the FETCH cycle; leaves the DUT in WAIT.
  task automatic stepRow();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
  endtask

  initial begin
    logic [2:0] lvls [3];
    logic [4:0] lens [3];
    logic [7:0] lastRow [3];
    lvls = '{3'd2, 3'd4, 3'd6};
    lens = '{5'd10, 5'd15, 5'd20};
    lastRow = '{8'h04, 8'h04, 8'h02};

    //          start step pause lvl  prog   row    rv ld gd err
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd2, 5'd1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'd2, 5'd1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'd2, 5'd2, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 3'd2, 5'd2, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 3'd2, 5'd2, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 3'd2, 5'd2, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 3'd2, 5'd2, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 3'd2, 5'd3, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 3'd2, 5'd3, 8'h0C, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 3'd2, 5'd4, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 3'd2, 5'd4, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 3'd2, 5'd4, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; step = 1'b0; pause = 1'b0; forceZero = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkAll("reset", 3'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Step and Pause in IDLE do nothing
    step = 1'b1; pause = 1'b1;
    tick();
    step = 1'b0; pause = 1'b0;
    checkAll("idleStep", 3'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start; step = vecs[i].step; pause = vecs[i].pause;
      tick();
      checkAll($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prog, vecs[i].row,
               vecs[i].rv, vecs[i].ld, vecs[i].gd, vecs[i].err);
    end
    start = 1'b0; step = 1'b0; pause = 1'b0;

    // Finish level 2 and roll into level 4
    for (int p = 5; p <= 10; p++) stepRow();
    checkAll("lvl2Last", 3'd2, 5'd10, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    checkAll("lvl2End", 3'd2, 5'd10, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkAll("lvl4Fetch", 3'd4, 5'd1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkAll("lvl4First", 3'd4, 5'd1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);

    // Mid-level reset, then reset dominating Start
    for (int p = 2; p <= 7; p++) stepRow();
    checkAll("lvl4Prog7", 3'd4, 5'd7, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkAll("midReset", 3'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; start = 1'b1; step = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; step = 1'b0;
    checkAll("resetStart", 3'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkAll("stillIdle", 3'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full game run
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkAll("runStart", 3'd2, 5'd1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 3; l++) begin
      for (int p = 2; p <= int'(lens[l]); p++) stepRow();
      checkAll($sformatf("run%0dLast", l), lvls[l], lens[l], lastRow[l], 1'b1, 1'b0, 1'b0, 1'b0);
      step = 1'b1;
      tick();
      step = 1'b0;
      checkAll($sformatf("run%0dEnd", l), lvls[l], lens[l], lastRow[l], 1'b0, 1'b1, 1'b0, 1'b0);
      if (l < 2) begin
        tick();
        tick();
        checkAll($sformatf("run%0dNext", l), lvls[l + 1], 5'd1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
    tick();
    checkAll("gameDone", 3'd0, 5'd0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      checkAll($sformatf("doneHold%0d", i), 3'd0, 5'd0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Restart from DONE, then a zero row sets the sticky error
    start = 1'b1;
    tick();
    start = 1'b0;
    checkAll("restart", 3'd2, 5'd1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    forceZero = 1'b1;
    stepRow();
    forceZero = 1'b0;
    checkAll("zeroRow", 3'd2, 5'd2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    stepRow();
    stepRow();
    checkAll("errSticky", 3'd2, 5'd4, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1);
    start = 1'b1; step = 1'b1;
    tick();
    start = 1'b0; step = 1'b0;
    checkAll("errClear", 3'd2, 5'd1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
